layered_objects_mux: RTL and testbench
======================================

Name: layered_objects_mux

Overview:
- Parametrised, pipelined successor to the fixed-list object priority mux.
- Selects the highest-priority opaque layer per pixel from N_LAYERS flattened inputs, with fallback to the background.
- Adds per-layer enable, transparent-colour keying, frame-synchronous flashing of selected layers, and per-frame collision reporting.
- Sits between the object drawers and the VGA controller; the output is 24-bit RGB.

Parameters:
- N_LAYERS, 12, number of object layers; index 0 = highest priority.
- R_BITS, 3, red bits in packed pixel.
- G_BITS, 3, green bits in packed pixel.
- B_BITS, 2, blue bits in packed pixel; RGB_W = R_BITS+G_BITS+B_BITS, packed {R,G,B}, each component 1..8 bits.
- FLASH_FRAMES, 8, frames per flash half-period (>=1).
- FLASH_MASK, 1, N_LAYERS-bit mask of layers blanked during the flash-off phase.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- drawReq  in  N_LAYERS  per-layer drawing request
- layerRGB  in  N_LAYERS*RGB_W  packed colours; layer i at [i*RGB_W +: RGB_W]
- backGroundRGB  in  RGB_W  colour used when no layer wins
- layerEnable  in  N_LAYERS  per-layer enable (0 = layer ignored entirely)
- transparentRGB  in  RGB_W  colour key; a matching layer pixel is not drawn
- startOfFrame  in  1  one-cycle pulse at first pixel of each frame
- flashEn  in  1  enables flash blanking of FLASH_MASK layers
- redOut  out  8  expanded red
- greenOut  out  8  expanded green
- blueOut  out  8  expanded blue
- topLayerIdx  out  $clog2(N_LAYERS+1)  winning layer index; N_LAYERS = background
- collisionOut  out  N_LAYERS  layers that overlapped another layer during the previous complete frame

Behaviour:
- Effective request: eff[i] = drawReq[i] & layerEnable[i] & (layer i colour != transparentRGB).
- Stage 1 (registered): eff, all layer colours, backGroundRGB, startOfFrame.
- Stage 2 (registered): priority select on the stage-1 values.
  - The lowest i with eff[i] & !blank[i] wins.
  - blank[i] = flashEn & flashPhase & FLASH_MASK[i].
  - No winner: background, topLayerIdx = N_LAYERS.
- Latency: exactly 2 clocks from inputs to redOut/greenOut/blueOut/topLayerIdx; throughput 1 pixel/clock, no stalls.
- Colour expansion: each component is left-aligned into 8 bits, with the remaining low bits filled by copies of that component's LSB.
  - Example: R=3'b101 gives 8'b10111111.
  - A component already 8 bits wide is passed unchanged.
- Flash counter:
  - frameCnt (0..FLASH_FRAMES-1) increments on each stage-1 startOfFrame.
  - On wrap to 0, flashPhase toggles.
  - Counts regardless of flashEn.
  - flashPhase changes take effect on the pixel that carries startOfFrame.
- Collision accumulator, per stage-1 pixel:
  - If popcount(eff) >= 2, acc |= eff. Flash blanking is NOT applied; blanked layers still collide.
  - On a stage-1 startOfFrame: collisionOut <= acc (excluding the current pixel), and acc <= the current pixel's contribution only.
  - collisionOut is therefore stable for a whole frame and updates 1 clock after startOfFrame reaches stage 1 (2 clocks after the input pulse).
- Reset (synchronous, overrides everything, may occur mid-frame):
  - All pipeline registers are cleared; eff = 0, startOfFrame = 0.
  - redOut = greenOut = blueOut = 0.
  - topLayerIdx = N_LAYERS.
  - collisionOut = 0, acc = 0, frameCnt = 0, flashPhase = 0.
  - Outputs show background-derived values from the second clock after reset deasserts.
- Boundaries:
  - All layers disabled: background.
  - transparentRGB equal to backGroundRGB does not key the background.
  - startOfFrame on consecutive clocks: each pulse is a frame boundary; the empty frame reports 0.
  - FLASH_FRAMES=1: phase toggles every frame.

Test Plan:
1. Reset, then drawReq=0, backGroundRGB=8'hFF → after 2 clocks {redOut,greenOut,blueOut}=FF,FF,FF and topLayerIdx=12; during reset, outputs 0 and topLayerIdx=12.
2. Layers 3 and 7 requested, layer3=8'hE0, layer7=8'h1C, all enabled → 2 clocks later red=8'hFF, green=0, blue=0, idx=3; then layer3 colour = transparentRGB=8'hE0 → idx=7, green=8'hFF.
3. Layer 3 requested with layerEnable[3]=0 → layer 7 wins; layerEnable=0 for all → background; verify exact 2-cycle latency with single-cycle request pulses.
4. FLASH_FRAMES=2, FLASH_MASK bit 0, flashEn=1, layer0+layer5 drawn every pixel → frames 0–1 show idx 0, frames 2–3 show idx 5, frames 4–5 idx 0; with flashEn=0, always idx 0.
5. Frame N: layers 2 and 4 overlap on one pixel, layer 9 alone elsewhere → after next startOfFrame collisionOut=12'h014, held all of frame N+1; frame N+1 has no overlaps → 0 after following startOfFrame.
6. Assert reset mid-frame while acc is nonzero and flashPhase=1 → collisionOut=0, phase=0; the next full frame reports only collisions occurring after reset.

Source files
------------

// File: rtl/layered_objects_mux.sv
// Per-pixel layer priority mux with per-layer enable, colour keying, frame-synchronous
// flash blanking and per-frame collision reporting; two-stage pipeline, 24-bit RGB out.
module layered_objects_mux #(
    parameter int N_LAYERS = 12,
    parameter int R_BITS = 3,
    parameter int G_BITS = 3,
    parameter int B_BITS = 2,
    parameter int FLASH_FRAMES = 8,
    parameter logic [N_LAYERS-1:0] FLASH_MASK = N_LAYERS'(1),
    localparam int RGB_W = R_BITS + G_BITS + B_BITS,
    localparam int IDX_W = $clog2(N_LAYERS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_LAYERS-1:0]       drawReq,
    input  logic [N_LAYERS*RGB_W-1:0] layerRGB,
    input  logic [RGB_W-1:0]          backGroundRGB,
    input  logic [N_LAYERS-1:0]       layerEnable,
    input  logic [RGB_W-1:0]          transparentRGB,
    input  logic                      startOfFrame,
    input  logic                      flashEn,
    output logic [7:0]                redOut,
    output logic [7:0]                greenOut,
    output logic [7:0]                blueOut,
    output logic [IDX_W-1:0]          topLayerIdx,
    output logic [N_LAYERS-1:0]       collisionOut
);

    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

    // Left-align a right-justified component of 'width' bits into 8 bits, filling with its LSB.
    function automatic logic [7:0] expand_comp(input logic [7:0] comp, input int width);
        logic [7:0] res;
        res = 8'd0;
        for (int b = 0; b < 8; b++) begin
            if (b >= 8 - width) begin
                res[b] = comp[b - (8 - width)];
            end else begin
                res[b] = comp[0];
            end
        end
        return res;
    endfunction

    logic [N_LAYERS-1:0]       eff_in_s;
    logic [N_LAYERS-1:0]       eff_r;
    logic [N_LAYERS*RGB_W-1:0] rgb_r;
    logic [RGB_W-1:0]          bg_r;
    logic                      sof_r;
    logic                      flash_en_r;
    logic [CNT_W-1:0]          frame_cnt_r;
    logic                      flash_phase_r;
    logic [N_LAYERS-1:0]       acc_r;
    logic [N_LAYERS-1:0]       coll_r;
    logic                      wrap_s;
    logic                      phase_s;
    logic [N_LAYERS-1:0]       blank_s;
    logic [N_LAYERS-1:0]       cand_s;
    logic [N_LAYERS-1:0]       contrib_s;
    logic [IDX_W-1:0]          sel_idx_s;
    logic [RGB_W-1:0]          sel_rgb_s;
    logic [7:0]                red_r;
    logic [7:0]                green_r;
    logic [7:0]                blue_r;
    logic [IDX_W-1:0]          idx_r;

    // Effective request per layer: requested, enabled and not keyed out.
    always_comb begin
        eff_in_s = {N_LAYERS{1'b0}};
        for (int i = 0; i < N_LAYERS; i++) begin
            eff_in_s[i] = drawReq[i] & layerEnable[i] &
                          (layerRGB[i*RGB_W +: RGB_W] != transparentRGB);
        end
    end

    // Stage 1 input capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            eff_r      <= {N_LAYERS{1'b0}};
            rgb_r      <= {(N_LAYERS*RGB_W){1'b0}};
            bg_r       <= {RGB_W{1'b0}};
            sof_r      <= 1'b0;
            flash_en_r <= 1'b0;
        end else begin
            eff_r      <= eff_in_s;
            rgb_r      <= layerRGB;
            bg_r       <= backGroundRGB;
            sof_r      <= startOfFrame;
            flash_en_r <= flashEn;
        end
    end

    // The phase flip is applied to the very pixel carrying startOfFrame, hence the bypass.
    always_comb begin
        wrap_s    = sof_r && (frame_cnt_r == CNT_LAST);
        phase_s   = wrap_s ? ~flash_phase_r : flash_phase_r;
        blank_s   = (flash_en_r && phase_s) ? FLASH_MASK : {N_LAYERS{1'b0}};
        cand_s    = eff_r & ~blank_s;
        contrib_s = ((eff_r & (eff_r - N_LAYERS'(1))) != {N_LAYERS{1'b0}}) ? eff_r
                                                                           : {N_LAYERS{1'b0}};
    end

    // Frame counter, flash phase and collision accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r   <= {CNT_W{1'b0}};
            flash_phase_r <= 1'b0;
            acc_r         <= {N_LAYERS{1'b0}};
            coll_r        <= {N_LAYERS{1'b0}};
        end else if (sof_r) begin
            frame_cnt_r   <= wrap_s ? {CNT_W{1'b0}} : frame_cnt_r + CNT_W'(1);
            flash_phase_r <= phase_s;
            acc_r         <= contrib_s;
            coll_r        <= acc_r;
        end else begin
            frame_cnt_r   <= frame_cnt_r;
            flash_phase_r <= flash_phase_r;
            acc_r         <= acc_r | contrib_s;
            coll_r        <= coll_r;
        end
    end

    // Priority select: scanning downwards lets the lowest candidate index win.
    always_comb begin
        sel_idx_s = IDX_W'(N_LAYERS);
        sel_rgb_s = bg_r;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                sel_idx_s = IDX_W'(i);
                sel_rgb_s = rgb_r[i*RGB_W +: RGB_W];
            end else begin
                sel_idx_s = sel_idx_s;
                sel_rgb_s = sel_rgb_s;
            end
        end
    end

    // Stage 2 output registers with colour expansion.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_r   <= 8'd0;
            green_r <= 8'd0;
            blue_r  <= 8'd0;
            idx_r   <= IDX_W'(N_LAYERS);
        end else begin
            red_r   <= expand_comp(8'(sel_rgb_s[RGB_W-1 -: R_BITS]), R_BITS);
            green_r <= expand_comp(8'(sel_rgb_s[B_BITS +: G_BITS]), G_BITS);
            blue_r  <= expand_comp(8'(sel_rgb_s[0 +: B_BITS]), B_BITS);
            idx_r   <= sel_idx_s;
        end
    end

    assign redOut       = red_r;
    assign greenOut     = green_r;
    assign blueOut      = blue_r;
    assign topLayerIdx  = idx_r;
    assign collisionOut = coll_r;

endmodule

// File: tb/tb_layered_objects_mux.sv
// Self-checking bench for layered_objects_mux: directed scenarios plus random pixels,
// compared against a per-pixel behavioural model with a one-entry latency pipe.
module tb_layered_objects_mux;

    localparam int NL = 12;
    localparam int FF = 2;
    localparam logic [NL-1:0] FMASK = 12'h001;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] drawReq;
    logic [95:0] layerRGB;
    logic [7:0]  backGroundRGB;
    logic [11:0] layerEnable;
    logic [7:0]  transparentRGB;
    logic        startOfFrame;
    logic        flashEn;
    logic [7:0]  redOut;
    logic [7:0]  greenOut;
    logic [7:0]  blueOut;
    logic [3:0]  topLayerIdx;
    logic [11:0] collisionOut;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_cnt;
    bit          m_phase;
    logic [11:0] m_acc;
    logic [11:0] m_coll;
    logic [23:0] exp_rgb;
    int          exp_idx;
    logic [11:0] exp_coll;
    bit          exp_valid = 1'b0;

    layered_objects_mux #(
        .N_LAYERS(NL), .R_BITS(3), .G_BITS(3), .B_BITS(2),
        .FLASH_FRAMES(FF), .FLASH_MASK(FMASK)
    ) dut (
        .clk(clk), .reset(reset), .drawReq(drawReq), .layerRGB(layerRGB),
        .backGroundRGB(backGroundRGB), .layerEnable(layerEnable),
        .transparentRGB(transparentRGB), .startOfFrame(startOfFrame), .flashEn(flashEn),
        .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut),
        .topLayerIdx(topLayerIdx), .collisionOut(collisionOut)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] widen(input int comp, input int w);
        int v;
        v = comp << (8 - w);
        if ((comp & 1) != 0) v = v | ((1 << (8 - w)) - 1);
        return 8'(v);
    endfunction

    function automatic logic [7:0] lcol(input int i);
        return layerRGB[i*8 +: 8];
    endfunction

    // Apply current inputs for one clock, then check what should have emerged.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            logic [11:0] eff;
            logic [11:0] contrib;
            logic [23:0] e_rgb;
            logic [7:0]  col;
            int          e_idx;
            if (reset) begin
                m_cnt = 0; m_phase = 1'b0; m_acc = 12'h000; m_coll = 12'h000;
                e_rgb = 24'h0; e_idx = NL;
                exp_rgb = 24'h0; exp_idx = NL; exp_coll = 12'h000; exp_valid = 1'b1;
            end else begin
                for (int i = 0; i < NL; i++)
                    eff[i] = drawReq[i] && layerEnable[i] && (lcol(i) != transparentRGB);
                if (startOfFrame) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == FF) begin m_cnt = 0; m_phase = !m_phase; end
                end
                contrib = ($countones(eff) >= 2) ? eff : 12'h000;
                if (startOfFrame) begin m_coll = m_acc; m_acc = contrib; end
                else m_acc = m_acc | contrib;
                e_idx = NL;
                for (int i = 0; i < NL; i++) begin
                    if (eff[i] && !(flashEn && m_phase && FMASK[i])) begin e_idx = i; break; end
                end
                col = (e_idx == NL) ? backGroundRGB : lcol(e_idx);
                e_rgb = {widen(int'(col[7:5]), 3), widen(int'(col[4:2]), 3), widen(int'(col[1:0]), 2)};
            end
            @(posedge clk);
            #1;
            if (exp_valid) begin
                check_eq("rgb",  32'({redOut, greenOut, blueOut}), 32'(exp_rgb));
                check_eq("idx",  32'(topLayerIdx), 32'(exp_idx));
                check_eq("coll", 32'(collisionOut), 32'(exp_coll));
            end
            exp_rgb = e_rgb; exp_idx = e_idx; exp_coll = m_coll;
        end
    endtask

    task automatic default_colours();
        for (int i = 0; i < NL; i++) layerRGB[i*8 +: 8] = 8'(8'h11 * (i + 1));
    endtask

    initial begin
        int pix;
        int flen;
        reset = 1'b1; drawReq = 12'h000; layerRGB = 96'h0; backGroundRGB = 8'h00;
        layerEnable = 12'hFFF; transparentRGB = 8'h00; startOfFrame = 1'b0; flashEn = 1'b0;
        default_colours();

        // 1: reset then background only
        tick(3);
        check_eq("t1_rst_idx", 32'(topLayerIdx), 32'd12);
        reset = 1'b0; backGroundRGB = 8'hFF;
        tick(2);
        check_eq("t1_bg_rgb", 32'({redOut, greenOut, blueOut}), 32'h00FFFFFF);
        check_eq("t1_bg_idx", 32'(topLayerIdx), 32'd12);

        // 2: priority and transparent keying
        layerRGB[3*8 +: 8] = 8'hE0; layerRGB[7*8 +: 8] = 8'h1C; drawReq = 12'h088;
        tick(2);
        check_eq("t2_rgb3", 32'({redOut, greenOut, blueOut}), 32'h00FF0000);
        check_eq("t2_idx3", 32'(topLayerIdx), 32'd3);
        transparentRGB = 8'hE0;
        tick(2);
        check_eq("t2_rgb7", 32'({redOut, greenOut, blueOut}), 32'h0000FF00);
        check_eq("t2_idx7", 32'(topLayerIdx), 32'd7);

        // 3: enables and single-cycle pulses
        transparentRGB = 8'h00; layerEnable = 12'hFF7;
        tick(2);
        check_eq("t3_idx7", 32'(topLayerIdx), 32'd7);
        layerEnable = 12'h000; tick(3);
        layerEnable = 12'hFFF;
        for (int i = 0; i < 6; i++) begin drawReq = (i % 2 == 0) ? 12'h088 : 12'h000; tick(); end
        drawReq = 12'h000; tick(2);

        // 4: flashing of layer 0 over layer 5
        default_colours();
        reset = 1'b1; tick(); reset = 1'b0;
        flashEn = 1'b1; drawReq = 12'h021;
        for (int f = 0; f < 7; f++) begin
            startOfFrame = (f != 0); tick(); startOfFrame = 1'b0; tick(3);
        end
        flashEn = 1'b0;
        for (int f = 0; f < 3; f++) begin startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick(3); end

        // 5: collision report
        drawReq = 12'h000; startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        drawReq = 12'h014; tick(); drawReq = 12'h200; tick(); drawReq = 12'h000; tick(2);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        check_eq("t5_coll", 32'(collisionOut), 32'h014);
        tick(4);
        check_eq("t5_hold", 32'(collisionOut), 32'h014);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        check_eq("t5_empty", 32'(collisionOut), 32'h000);

        // 6: reset mid-frame with pending collisions and phase set
        reset = 1'b1; tick(); reset = 1'b0;
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick(2);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        drawReq = 12'h014; tick(); drawReq = 12'h021; flashEn = 1'b1; tick(2);
        check_eq("t6_idx_ph1", 32'(topLayerIdx), 32'd5);
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("t6_rst_coll", 32'(collisionOut), 32'h000);
        tick(2);
        check_eq("t6_idx_ph0", 32'(topLayerIdx), 32'd0);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        check_eq("t6_coll", 32'(collisionOut), 32'h021);
        flashEn = 1'b0; drawReq = 12'h000; tick(2);

        // Random pixels, frames, keying, flashing and occasional reset
        pix = 0; flen = 6;
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            drawReq = 12'($urandom) & 12'($urandom);
            layerEnable = 12'($urandom) | 12'($urandom);
            if ($urandom_range(0, 49) == 0) transparentRGB = 8'($urandom);
            if ($urandom_range(0, 99) == 0) flashEn = !flashEn;
            backGroundRGB = ($urandom_range(0, 7) == 0) ? transparentRGB : 8'($urandom);
            for (int i = 0; i < NL; i++)
                layerRGB[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? transparentRGB : 8'($urandom);
            pix++;
            startOfFrame = (pix >= flen) || ($urandom_range(0, 40) == 0);
            if (startOfFrame) begin pix = 0; flen = $urandom_range(3, 12); end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
